// File: rtl/ff_video_pkg.sv
// Shared video types for the foodfight scandoubler: RGB field layout, line-buffer word, read-side states.
// The dim helper halves each colour channel and is used for scanline shading on the repeated pass.
package ff_video_pkg;
    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;
    localparam int PIX_W = 9;

    typedef struct packed {
        logic       blank;
        logic [7:0] rgb;
    } pix_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_PASS_A = 2'd1,
        RD_PASS_B = 2'd2
    } rd_state_t;

    function automatic logic [7:0] dim(input logic [7:0] rgb);
        logic [7:0] d;
        d = '0;
        d[R_MSB:R_LSB] = rgb[R_MSB:R_LSB] >> 1;
        d[G_MSB:G_LSB] = rgb[G_MSB:G_LSB] >> 1;
        d[B_MSB:B_LSB] = rgb[B_MSB:B_LSB] >> 1;
        return d;
    endfunction
endpackage

// File: rtl/ff_scandoubler_if.sv
// Video bundle between the core (master: drives 15 kHz inputs) and the scandoubler (slave: drives doubled outputs).
// No backpressure: the video stream is free-running.
interface ff_scandoubler_if;
    logic       pix_ce;
    logic       in_hsync;
    logic       in_vsync;
    logic       in_blank;
    logic [7:0] in_rgb;
    logic       out_hsync;
    logic       out_vsync;
    logic       out_blank;
    logic [7:0] out_rgb;

    modport master (
        output pix_ce, in_hsync, in_vsync, in_blank, in_rgb,
        input  out_hsync, out_vsync, out_blank, out_rgb
    );

    modport slave (
        input  pix_ce, in_hsync, in_vsync, in_blank, in_rgb,
        output out_hsync, out_vsync, out_blank, out_rgb
    );
endinterface

// File: rtl/ff_linebuf.sv
// Ping-pong line buffer: 2 banks of 2**AW pixel words, bank bit is the address MSB.
// One write port, one read port with 1-cycle registered data; no backpressure.
module ff_linebuf
    import ff_video_pkg::*;
#(
    parameter int AW = 9
) (
    input  logic        clk,
    input  logic        we,
    input  logic [AW:0] waddr,
    input  pix_t        wdata,
    input  logic [AW:0] raddr,
    output pix_t        rdata
);
    pix_t mem_q [0:(1 << (AW + 1)) - 1];
    pix_t rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/ff_scandoubler.sv
// Scandoubler: captures each 15 kHz line at pix_ce and replays it twice at clk rate; first pixel 3 clk after hsync rise.
// No backpressure (free-running video); FF_SCANLINES_EN dims the second pass of each line pair.
module ff_scandoubler
    import ff_video_pkg::*;
#(
    parameter int LINE_MAX = 512,
    parameter int AW       = 9,
    parameter int HS_WIDTH = 48
) (
    input  logic              clk_12mhz,
    input  logic              reset,
    ff_scandoubler_if.slave   vid
);
    localparam logic [AW:0] LEN_MAX = (AW + 1)'(LINE_MAX);
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0] HS_W    = (AW + 1)'(HS_WIDTH);

    logic        ce_q, hs_q, hs_prev_q, vs_q, blank_q;
    logic [7:0]  rgb_q;
    logic        synced_q, synced_d;
    logic        wr_bank_q, wr_bank_d;
    logic [AW:0] wr_cnt_q, wr_cnt_d;
    logic [AW:0] line_len_q, line_len_d;
    logic        rd_bank_q, rd_bank_d;
    logic [AW:0] rd_cnt_q, rd_cnt_d;
    rd_state_t   rd_state_q, rd_state_d;
    logic        vs_line_q, vs_line_d;
    logic        out_hsync_q, out_hsync_d;
    logic        out_vsync_q, out_vsync_d;
    logic        out_blank_q, out_blank_d;
    logic [7:0]  out_rgb_q, out_rgb_d;

    logic          hs_rise, rd_last, wr_bank_w, pass_on;
    logic [AW-1:0] wr_addr;
    logic [7:0]    shade;
    pix_t          wr_pix, rd_pix;

    assign hs_rise = hs_q & ~hs_prev_q;
    assign rd_last = (rd_cnt_q == (line_len_q - CNT_ONE));
    assign wr_pix  = {blank_q, rgb_q};

    always_comb begin
        synced_d   = synced_q;
        wr_bank_d  = wr_bank_q;
        wr_cnt_d   = wr_cnt_q;
        line_len_d = line_len_q;
        rd_bank_d  = rd_bank_q;
        rd_cnt_d   = rd_cnt_q;
        rd_state_d = rd_state_q;
        vs_line_d  = vs_line_q;
        wr_bank_w  = wr_bank_q;
        // Once the count saturates, the last slot keeps absorbing the line's tail pixels.
        wr_addr    = (wr_cnt_q == LEN_MAX) ? {AW{1'b1}} : wr_cnt_q[AW-1:0];
        if (ce_q && (wr_cnt_q != LEN_MAX)) begin
            wr_cnt_d = wr_cnt_q + CNT_ONE;
        end
        if (hs_rise) begin
            wr_bank_d  = ~wr_bank_q;
            wr_bank_w  = ~wr_bank_q;
            wr_addr    = '0;
            wr_cnt_d   = ce_q ? CNT_ONE : '0;
            synced_d   = 1'b1;
            // A line that began before reset release (or before the first hsync) is not replayed.
            line_len_d = synced_q ? wr_cnt_q : '0;
            rd_bank_d  = wr_bank_q;
            rd_cnt_d   = '0;
            rd_state_d = (synced_q && (wr_cnt_q != '0)) ? RD_PASS_A : RD_IDLE;
            vs_line_d  = vs_q;
        end else begin
            case (rd_state_q)
                RD_PASS_A: begin
                    rd_cnt_d = rd_last ? '0 : rd_cnt_q + CNT_ONE;
                    if (rd_last) rd_state_d = RD_PASS_B;
                end
                RD_PASS_B: begin
                    rd_cnt_d = rd_last ? '0 : rd_cnt_q + CNT_ONE;
                    if (rd_last) rd_state_d = RD_IDLE;
                end
                default: ;
            endcase
        end
    end

    // RAM data arriving now belongs to rd_cnt_q/rd_state_q, so outputs are built from the _q state.
    always_comb begin
        pass_on     = (rd_state_q != RD_IDLE);
        out_blank_d = ~pass_on | rd_pix.blank;
        shade       = rd_pix.rgb;
`ifdef FF_SCANLINES_EN
        if (rd_state_q == RD_PASS_B) shade = dim(rd_pix.rgb);
`endif
        out_rgb_d   = out_blank_d ? 8'h00 : shade;
        out_hsync_d = pass_on && (rd_cnt_q < HS_W);
        out_vsync_d = ((rd_state_q == RD_PASS_A) && (rd_cnt_q == '0)) ? vs_line_q : out_vsync_q;
    end

    always_ff @(posedge clk_12mhz or posedge reset) begin
        if (reset) begin
            ce_q        <= 1'b0;
            hs_q        <= 1'b0;
            hs_prev_q   <= 1'b0;
            vs_q        <= 1'b0;
            blank_q     <= 1'b0;
            rgb_q       <= '0;
            synced_q    <= 1'b0;
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            line_len_q  <= '0;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            rd_state_q  <= RD_IDLE;
            vs_line_q   <= 1'b0;
            out_hsync_q <= 1'b0;
            out_vsync_q <= 1'b0;
            out_blank_q <= 1'b0;
            out_rgb_q   <= '0;
        end else begin
            ce_q        <= vid.pix_ce;
            hs_q        <= vid.in_hsync;
            hs_prev_q   <= hs_q;
            vs_q        <= vid.in_vsync;
            blank_q     <= vid.in_blank;
            rgb_q       <= vid.in_rgb;
            synced_q    <= synced_d;
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            line_len_q  <= line_len_d;
            rd_bank_q   <= rd_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_state_q  <= rd_state_d;
            vs_line_q   <= vs_line_d;
            out_hsync_q <= out_hsync_d;
            out_vsync_q <= out_vsync_d;
            out_blank_q <= out_blank_d;
            out_rgb_q   <= out_rgb_d;
        end
    end

    ff_linebuf #(.AW(AW)) u_linebuf (
        .clk   (clk_12mhz),
        .we    (ce_q),
        .waddr ({wr_bank_w, wr_addr}),
        .wdata (wr_pix),
        .raddr ({rd_bank_d, rd_cnt_d[AW-1:0]}),
        .rdata (rd_pix)
    );

    assign vid.out_hsync = out_hsync_q;
    assign vid.out_vsync = out_vsync_q;
    assign vid.out_blank = out_blank_q;
    assign vid.out_rgb   = out_rgb_q;
endmodule
